// File: rtl/nios_test_board_pio_out_ctrl.sv
// Avalon-MM output PIO: data/set/clear registers and a timed inverting pulse.
// The pulse register, counter and FSM exist only when PIO_OUT_PULSE_EN is defined.
module nios_test_board_pio_out_ctrl #(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PULSE_LEN   = 12000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [1:0] A_DATA  = 2'd0;
    localparam logic [1:0] A_PULSE = 2'd1;
    localparam logic [1:0] A_SET   = 2'd2;
    localparam logic [1:0] A_CLR   = 2'd3;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_reg;
    logic [31:0]      rd_next;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wdata     = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata[31:WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr_en) begin
            unique case (address)
                A_DATA:  data_reg <= wdata;
                A_SET:   data_reg <= data_reg | wdata;
                A_CLR:   data_reg <= data_reg & ~wdata;
                default: data_reg <= data_reg;
            endcase
        end
    end

`ifdef PIO_OUT_PULSE_EN
    localparam int               CW   = $clog2(PULSE_LEN) + 1;
    localparam logic [CW-1:0]    LOAD = CW'(PULSE_LEN - 1);

    typedef enum logic {IDLE, PULSING} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pulse_wr;
    logic             active;

    assign pulse_wr = wr_en && (address == A_PULSE);
    assign active   = (state_q == PULSING);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    // A PULSE write wins over expiry; a zero mask aborts the pulse.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pulse_wr && wdata != '0) begin
                    state_d = PULSING;
                    mask_d  = wdata;
                    cnt_d   = LOAD;
                end
            end
            PULSING: begin
                if (pulse_wr && wdata != '0) begin
                    mask_d = wdata;
                    cnt_d  = LOAD;
                end else if (pulse_wr || cnt_q == '0) begin
                    state_d = IDLE;
                    mask_d  = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    assign out_port = data_reg ^ (active ? mask_q : '0);
`else
    assign out_port = data_reg;
`endif

    always_comb begin
        rd_next = '0;
        unique case (address)
            A_DATA: rd_next[WIDTH-1:0] = data_reg;
`ifdef PIO_OUT_PULSE_EN
            A_PULSE: begin
                rd_next[WIDTH-1:0] = mask_q;
                rd_next[31]        = active;
            end
`endif
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_nios_test_board_pio_out_ctrl.sv
// Self-checking bench for nios_test_board_pio_out_ctrl (WIDTH=3, PULSE_LEN=4).
// Pulse checks run when PIO_OUT_PULSE_EN is defined, else the disabled-path checks.
module tb_nios_test_board_pio_out_ctrl;

    localparam int         WIDTH = 3;
    localparam logic [2:0] RV    = 3'b101;
    localparam int         PL    = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [2:0]  out_port;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model: pulse is active while the edge count is below m_end.
    int          cyc;
    int          m_end;
    logic [2:0]  m_data;
    logic [2:0]  m_mask;
    logic [31:0] m_rd;

    always #5 clk = ~clk;

    nios_test_board_pio_out_ctrl #(
        .WIDTH(WIDTH),
        .RESET_VALUE(RV),
        .PULSE_LEN(PL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_out();
        return m_data ^ ((cyc < m_end) ? m_mask : 3'b000);
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        logic [2:0] w;
        bit         act;
        if (!reset_n) begin
            cyc    = 0;
            m_end  = 0;
            m_data = RV;
            m_mask = 3'b000;
            m_rd   = 32'd0;
        end else begin
            act = (cyc < m_end);
            case (address)
                2'd0: m_rd = {29'd0, m_data};
`ifdef PIO_OUT_PULSE_EN
                2'd1: m_rd = act ? {1'b1, 28'd0, m_mask} : 32'd0;
`endif
                default: m_rd = 32'd0;
            endcase
            cyc = cyc + 1;
            w = writedata[2:0];
            if (chipselect && !write_n) begin
                case (address)
                    2'd0: m_data = w;
                    2'd2: m_data = m_data | w;
                    2'd3: m_data = m_data & ~w;
                    default: begin
`ifdef PIO_OUT_PULSE_EN
                        if (w != 3'b000) begin
                            m_mask = w;
                            m_end  = cyc + PL;
                        end else begin
                            m_mask = 3'b000;
                            m_end  = 0;
                        end
`endif
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_port", {29'd0, out_port}, {29'd0, exp_out()});
            check("readdata", readdata, m_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call just after an edge; the write is sampled at the next edge.
    task automatic wr_now(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        address = 2'd2;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {29'd0, out_port}, 32'd5);
        check("rst_rd", readdata, 32'd0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clk);
        check("post_rst_out", {29'd0, out_port}, 32'd5);
        check("post_rst_rd", readdata, 32'd0);
        step();
        address = 2'd0;
        @(negedge clk);
        check("rd_not_yet", readdata, 32'd0);
        @(negedge clk);
        check("rd_data", readdata, 32'h0000_0005);

        step();
        wr_now(2'd0, 32'hFFFF_FFF8);
        @(negedge clk);
        check("data_wr", {29'd0, out_port}, 32'd0);
        step();
        wr_now(2'd2, 32'h6);
        @(negedge clk);
        check("outset", {29'd0, out_port}, 32'd6);
        step();
        wr_now(2'd3, 32'h2);
        @(negedge clk);
        check("outclear", {29'd0, out_port}, 32'd4);

`ifdef PIO_OUT_PULSE_EN
        step();
        wr_now(2'd0, 32'h1);
        step();
        wr_now(2'd1, 32'h3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pulse_on", {29'd0, out_port}, 32'd2);
            if (i == 1) check("pulse_rd", readdata, 32'h8000_0003);
        end
        @(negedge clk);
        check("pulse_off", {29'd0, out_port}, 32'd1);
        @(negedge clk);
        check("pulse_rd_off", readdata, 32'd0);

        step();
        wr_now(2'd1, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_retrig", {29'd0, out_port}, 32'd0);
        @(posedge clk);
        #1;
        wr_now(2'd1, 32'h4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("retrig_on", {29'd0, out_port}, 32'd5);
        end
        @(negedge clk);
        check("retrig_off", {29'd0, out_port}, 32'd1);

        step();
        wr_now(2'd1, 32'h2);
        wr_now(2'd1, 32'h0);
        @(negedge clk);
        check("abort", {29'd0, out_port}, 32'd1);

        step();
        wr_now(2'd1, 32'h7);
        @(negedge clk);
        check("pre_rst_pulse", {29'd0, out_port}, 32'd6);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", {29'd0, out_port}, 32'd5);
        check("async_rst_rd", readdata, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_resume_out", {29'd0, out_port}, 32'd5);
        check("no_resume_rd", readdata, 32'd0);
`else
        step();
        wr_now(2'd1, 32'h7);
        @(negedge clk);
        check("nopulse_out", {29'd0, out_port}, 32'd4);
        @(negedge clk);
        check("nopulse_rd", readdata, 32'd0);
`endif

        for (int i = 0; i < 500; i++) begin
            step();
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
        end
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (3) step();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
